// File: rtl/clock_set_ctrl_if.sv
// Front-panel bundle between board buttons and the CLOCK set inputs.
// The master side drives the raw buttons; the slave (controller) drives strobes and mode.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       set_hr;
  logic       set_min;
  logic       set_AMPM;
  logic [1:0] mode;
  logic       setting;

  modport master (
    output btn_mode, btn_up,
    input  set_hr, set_min, set_AMPM, mode, setting
  );

  modport slave (
    input  btn_mode, btn_up,
    output set_hr, set_min, set_AMPM, mode, setting
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Field-select controller: synchronizes MODE/UP, walks RUN->HR->MIN->AMPM,
// emits one-cycle set strobes with auto-repeat and an idle timeout back to RUN.
module clock_set_ctrl #(
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int TIMEOUT       = 10000
) (
  input logic             clk,
  input logic             rst,
  clock_set_ctrl_if.slave pnl
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HR   = 2'd1,
    SET_MIN  = 2'd2,
    SET_AMPM = 2'd3
  } state_e;

  localparam int REP_MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W    = $clog2(REP_MAXV + 1);
  localparam int TO_W     = $clog2(TIMEOUT + 1);

  localparam logic [REP_W-1:0] DLY_M1  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PER_M1  = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_MAX = {REP_W{1'b1}};
  localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = {TO_W{1'b1}};

  // Synchronizer and previous-level flops reset high so a held button is not a press.
  logic mode_s1_q, mode_s2_q, mode_prev_q;
  logic up_s1_q, up_s2_q, up_prev_q;

  state_e           state_q, state_d;
  logic             rep_on_q, rep_on_d;
  logic             rep_slow_q, rep_slow_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             hr_q, min_q, ampm_q;
  logic             hr_d, min_d, ampm_d;
  logic             fire;
  logic             mode_edge, up_edge;

  assign mode_edge = mode_s2_q & ~mode_prev_q;
  assign up_edge   = up_s2_q & ~up_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_s1_q   <= 1'b1;
      mode_s2_q   <= 1'b1;
      mode_prev_q <= 1'b1;
      up_s1_q     <= 1'b1;
      up_s2_q     <= 1'b1;
      up_prev_q   <= 1'b1;
    end else begin
      mode_s1_q   <= pnl.btn_mode;
      mode_s2_q   <= mode_s1_q;
      mode_prev_q <= mode_s2_q;
      up_s1_q     <= pnl.btn_up;
      up_s2_q     <= up_s1_q;
      up_prev_q   <= up_s2_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    rep_on_d   = rep_on_q;
    rep_slow_d = rep_slow_q;
    rep_cnt_d  = rep_cnt_q;
    to_cnt_d   = '0;
    fire       = 1'b0;
    if (state_q != RUN)
      to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
    if (rep_on_q && rep_cnt_q != REP_MAX)
      rep_cnt_d = rep_cnt_q + 1'b1;

    // Priority: MODE edge, RUN idle, UP edge, timeout, repeat release, repeat fire.
    if (mode_edge) begin
      case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_AMPM;
        default: state_d = RUN;
      endcase
      rep_on_d   = 1'b0;
      rep_slow_d = 1'b0;
      rep_cnt_d  = '0;
      to_cnt_d   = '0;
    end else if (state_q == RUN) begin
      rep_on_d   = 1'b0;
      rep_slow_d = 1'b0;
      rep_cnt_d  = '0;
    end else if (up_edge) begin
      fire       = 1'b1;
      rep_on_d   = (state_q != SET_AMPM);
      rep_slow_d = 1'b0;
      rep_cnt_d  = '0;
      to_cnt_d   = '0;
    end else if (to_cnt_q == TO_M1) begin
      state_d    = RUN;
      rep_on_d   = 1'b0;
      rep_slow_d = 1'b0;
      rep_cnt_d  = '0;
      to_cnt_d   = '0;
    end else if (rep_on_q && !up_s2_q) begin
      rep_on_d   = 1'b0;
      rep_slow_d = 1'b0;
      rep_cnt_d  = '0;
    end else if (rep_on_q && rep_cnt_q == (rep_slow_q ? PER_M1 : DLY_M1)) begin
      fire       = 1'b1;
      rep_slow_d = 1'b1;
      rep_cnt_d  = '0;
      to_cnt_d   = '0;
    end
  end

  assign hr_d   = fire && (state_q == SET_HR);
  assign min_d  = fire && (state_q == SET_MIN);
  assign ampm_d = fire && (state_q == SET_AMPM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      rep_on_q   <= 1'b0;
      rep_slow_q <= 1'b0;
      rep_cnt_q  <= '0;
      to_cnt_q   <= '0;
      hr_q       <= 1'b0;
      min_q      <= 1'b0;
      ampm_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rep_on_q   <= rep_on_d;
      rep_slow_q <= rep_slow_d;
      rep_cnt_q  <= rep_cnt_d;
      to_cnt_q   <= to_cnt_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      ampm_q     <= ampm_d;
    end
  end

  assign pnl.set_hr   = hr_q;
  assign pnl.set_min  = min_q;
  assign pnl.set_AMPM = ampm_q;
  assign pnl.mode     = state_q;
  assign pnl.setting  = (state_q != RUN);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed panel scenarios plus random button traffic,
// compared every cycle against a cycle-count based model of the panel rules.
module tb_clock_set_ctrl;

  localparam int RD = 8;
  localparam int RP = 4;
  localparam int TO = 32;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  clock_set_ctrl_if pnl ();

  clock_set_ctrl #(
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .TIMEOUT      (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pnl(pnl.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: levels reach the edge detector two samples late
  int q_m[$] = '{1, 1, 1};
  int q_u[$] = '{1, 1, 1};
  int e_mode = 0;
  bit e_hr = 0, e_min = 0, e_ampm = 0;
  bit rep_on = 0;
  int p_cyc = 0, idle_start = 0, cyc = 0;
  int m_hr = 0, m_min = 0, m_ampm = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_m = '{1, 1, 1};
      q_u = '{1, 1, 1};
      e_mode = 0; e_hr = 0; e_min = 0; e_ampm = 0;
      rep_on = 0; cyc = 0; idle_start = 0; p_cyc = 0;
    end else begin
      bit m_rise, u_rise, u_lvl, fire;
      int d;
      cyc++;
      m_rise = (q_m[1] != 0) && (q_m[0] == 0);
      u_rise = (q_u[1] != 0) && (q_u[0] == 0);
      u_lvl  = (q_u[1] != 0);
      fire = 0;
      d = cyc - p_cyc;
      if (m_rise) begin
        e_mode = (e_mode + 1) % 4;
        rep_on = 0;
        idle_start = cyc;
      end else if (e_mode == 0) begin
        rep_on = 0;
      end else if (u_rise) begin
        fire = 1;
        rep_on = (e_mode != 3);
        p_cyc = cyc;
        idle_start = cyc;
      end else if (cyc - idle_start == TO) begin
        e_mode = 0;
        rep_on = 0;
      end else if (rep_on && !u_lvl) begin
        rep_on = 0;
      end else if (rep_on && (d == RD || (d > RD && (d - RD) % RP == 0))) begin
        fire = 1;
        idle_start = cyc;
      end
      e_hr   = fire && e_mode == 1;
      e_min  = fire && e_mode == 2;
      e_ampm = fire && e_mode == 3;
      m_hr += int'(e_hr); m_min += int'(e_min); m_ampm += int'(e_ampm);
      void'(q_m.pop_front()); q_m.push_back(int'(pnl.btn_mode));
      void'(q_u.pop_front()); q_u.push_back(int'(pnl.btn_up));
    end
  end

  // scoreboard: every cycle, plus strobe tallies
  int n_hr = 0, n_min = 0, n_ampm = 0;
  always @(negedge clk) begin
    logic [1:0] em;
    em = e_mode[1:0];
    chk("outs", {26'd0, pnl.mode, pnl.setting, pnl.set_hr, pnl.set_min, pnl.set_AMPM},
        {26'd0, em, (e_mode != 0), e_hr, e_min, e_ampm});
    chk("onehot", 32'(($countones({pnl.set_hr, pnl.set_min, pnl.set_AMPM}) <= 1)), 32'd1);
    n_hr += int'(pnl.set_hr); n_min += int'(pnl.set_min); n_ampm += int'(pnl.set_AMPM);
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    pnl.btn_mode = 1'b1;
    step(2);
    pnl.btn_mode = 1'b0;
    step(4);
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 4 && e_mode != target; i++) press_mode();
  endtask

  int s_hr, s_min, s_ampm;
  task automatic snap();
    s_hr = n_hr; s_min = n_min; s_ampm = n_ampm;
  endtask

  initial begin
    rst = 1'b1;
    pnl.btn_mode = 1'b1;
    pnl.btn_up   = 1'b0;
    step(3);
    rst = 1'b0;
    snap();
    step(10);
    chk("rst_strobes", n_hr + n_min + n_ampm - s_hr - s_min - s_ampm, 0);
    chk("rst_mode", 32'(pnl.mode), 0);
    chk("rst_setting", 32'(pnl.setting), 0);
    pnl.btn_mode = 1'b0;
    step(3);

    // mode walk, then UP in RUN
    for (int k = 1; k <= 4; k++) begin
      press_mode();
      chk("mode_walk", 32'(pnl.mode), 32'(k % 4));
    end
    snap();
    pnl.btn_up = 1'b1; step(5); pnl.btn_up = 1'b0; step(4);
    chk("run_up", n_hr + n_min + n_ampm - s_hr - s_min - s_ampm, 0);

    // single press in SET_MIN with exact latency
    goto_mode(2);
    snap();
    pnl.btn_up = 1'b1;
    step(2);
    chk("min_pre", 32'(pnl.set_min), 0);
    step(1);
    chk("min_lat", 32'(pnl.set_min), 1);
    pnl.btn_up = 1'b0;
    step(1);
    chk("min_width", 32'(pnl.set_min), 0);
    step(5);
    chk("min_count", n_min - s_min, 1);
    chk("min_other", n_hr + n_ampm - s_hr - s_ampm, 0);

    // auto-repeat in SET_HR
    goto_mode(1);
    snap();
    pnl.btn_up = 1'b1; step(16); pnl.btn_up = 1'b0; step(8);
    chk("hr_repeat", n_hr - s_hr, 3);

    // no repeat in SET_AMPM
    goto_mode(3);
    snap();
    pnl.btn_up = 1'b1; step(40); pnl.btn_up = 1'b0; step(4);
    chk("ampm_once", n_ampm - s_ampm, 1);

    // MODE/UP collision, then timeout boundary
    goto_mode(1);
    snap();
    pnl.btn_mode = 1'b1; pnl.btn_up = 1'b1;
    step(2);
    pnl.btn_mode = 1'b0; pnl.btn_up = 1'b0;
    step(32);
    chk("coll_mode", 32'(pnl.mode), 2);
    chk("coll_strobe", n_hr + n_min + n_ampm - s_hr - s_min - s_ampm, 0);
    step(1);
    chk("timeout_mode", 32'(pnl.mode), 0);
    chk("timeout_setting", 32'(pnl.setting), 0);

    // reset mid-repeat
    goto_mode(2);
    pnl.btn_up = 1'b1;
    step(14);
    rst = 1'b1;
    #1;
    chk("rst_async", {27'd0, pnl.mode, pnl.set_hr, pnl.set_min, pnl.set_AMPM}, 0);
    step(2);
    rst = 1'b0;
    snap();
    step(20);
    chk("rst_held_up", n_hr + n_min + n_ampm - s_hr - s_min - s_ampm, 0);
    chk("rst_held_mode", 32'(pnl.mode), 0);
    pnl.btn_up = 1'b0;
    step(3);

    // random button traffic
    for (int it = 0; it < 150; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        rst = 1'b1; step($urandom_range(1, 3)); rst = 1'b0;
      end else if (r < 8) begin
        pnl.btn_mode = 1'b1; step($urandom_range(1, 3));
        pnl.btn_mode = 1'b0; step($urandom_range(1, 4));
      end else if (r < 16) begin
        pnl.btn_up = 1'b1; step($urandom_range(1, 30));
        pnl.btn_up = 1'b0; step($urandom_range(1, 6));
      end else if (r < 18) begin
        step($urandom_range(5, 40));
      end else begin
        pnl.btn_mode = 1'b1; pnl.btn_up = 1'b1; step($urandom_range(1, 12));
        pnl.btn_mode = 1'b0; step($urandom_range(0, 10));
        pnl.btn_up = 1'b0; step(2);
      end
    end
    step(5);
    chk("tot_hr", n_hr, m_hr);
    chk("tot_min", n_min, m_min);
    chk("tot_ampm", n_ampm, m_ampm);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
